// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output peripheral.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int unsigned NUM_PINS  = 16;

    typedef logic [NUM_PINS-1:0] pin_vec_t;

    // Prescaler register width; a single bit is kept even when CLK_DIV is 1.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags each counter step and the period wrap.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 o_tick,
    output logic [PWM_CNT_W-1:0] o_pwm_cnt,
    output logic                 o_wrap
);

    localparam int unsigned        PRESC_W   = presc_width(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0]   r_presc;
    logic [PWM_CNT_W-1:0] r_cnt;
    logic                 w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + PWM_CNT_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign o_tick    = w_tick;
    assign o_pwm_cnt = r_cnt;
    assign o_wrap    = w_tick && (r_cnt == '1);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as low, high or a shared PWM waveform whose duty is
// double-buffered and only reloaded at the period boundary.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] pwm_out,
    output logic                period_start
);

    pin_vec_t             w_en_out;
    pin_vec_t             w_en_pwm;
    pin_vec_t             r_pwm_out;
    logic [PWM_CNT_W-1:0] w_pwm_cnt;
    logic [PWM_CNT_W-1:0] r_duty_shadow;
    logic                 r_period_start;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_load;
    logic                 w_pwm_sig;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .o_tick   (w_tick),
        .o_pwm_cnt(w_pwm_cnt),
        .o_wrap   (w_wrap)
    );

    assign w_en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_load    = w_tick && w_wrap;
    assign w_pwm_sig = (r_duty_shadow == DUTY_FULL) || (w_pwm_cnt < r_duty_shadow);

    // Output enable dominates; a PWM-mode pin follows the waveform, otherwise it is held high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_shadow  <= '0;
            r_period_start <= 1'b0;
            r_pwm_out      <= '0;
        end else begin
            r_period_start <= w_load;
            if (w_load) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
            r_pwm_out <= w_en_out & (~w_en_pwm | {NUM_PINS{w_pwm_sig}});
        end
    end

    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;

endmodule
